// File: rtl/mult_seq_pkg.sv
// Shared state encoding and sizing constants for the shift-add multiply sequencer.
package mult_seq_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int STATE_W   = 3;
   localparam int CNT_W     = 4;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_LOAD  = 3'd1;
   localparam state_t S_ADD   = 3'd2;
   localparam state_t S_SHIFT = 3'd3;
   localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/mult_seq_counter.sv
// Iteration down-counter: synchronous clear/load, saturating decrement, zero flag.
module mult_seq_counter #(
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   // Decrement stops at zero so the count never wraps.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && !zero)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for a shift-add multiplier datapath (A:Q with carry, M operand).
// Optional MULT_SEQ_SKIP_ZERO_EN: zero multiplier bits shift directly from ADD.
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic       Q0,
   output logic       CLR_A,
   output logic       LDQ,
   output logic       LDA,
   output logic       MULT_EN,
   output logic       SR,
   output logic       BUSY,
   output logic       DONE,
   output logic [3:0] COUNT
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   state_t     state, nxt;
   logic       cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt;

   mult_seq_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (CNT_INIT),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   assign COUNT = cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // ABORT dominates every state, including START in IDLE.
   always_comb begin
      nxt      = state;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (ABORT) begin
         nxt     = S_IDLE;
         cnt_clr = 1'b1;
      end else begin
         case (state)
            S_IDLE:  if (START) nxt = S_LOAD;
            S_LOAD: begin
               nxt      = S_ADD;
               cnt_load = 1'b1;
            end
            S_ADD: begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
               if (Q0) begin
                  nxt = S_SHIFT;
               end else if (cnt_zero) begin
                  nxt = S_DONE;
               end else begin
                  nxt     = S_ADD;
                  cnt_dec = 1'b1;
               end
`else
               nxt = S_SHIFT;
`endif
            end
            S_SHIFT: begin
               if (cnt_zero) begin
                  nxt = S_DONE;
               end else begin
                  nxt     = S_ADD;
                  cnt_dec = 1'b1;
               end
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
         endcase
      end
   end

   // Moore decode; Q0 only qualifies the ADD-state strobes.
   always_comb begin
      CLR_A   = 1'b0;
      LDQ     = 1'b0;
      LDA     = 1'b0;
      MULT_EN = 1'b0;
      SR      = 1'b0;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      case (state)
         S_LOAD: begin
            CLR_A = 1'b1;
            LDQ   = 1'b1;
            BUSY  = 1'b1;
         end
         S_ADD: begin
            MULT_EN = Q0;
            LDA     = Q0;
            BUSY    = 1'b1;
`ifdef MULT_SEQ_SKIP_ZERO_EN
            SR      = ~Q0;
`endif
         end
         S_SHIFT: begin
            SR   = 1'b1;
            BUSY = 1'b1;
         end
         S_DONE:  DONE = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized self-checking bench: per-cycle control trace built from the bit pattern
// of the multiplier, plus a behavioural A:Q datapath whose final product is checked.
module tb_mult_sequencer;

   localparam int W = 8;

   logic       CLK = 1'b0;
   logic       RST_N, START, ABORT, Q0;
   logic       CLR_A, LDQ, LDA, MULT_EN, SR, BUSY, DONE;
   logic [3:0] COUNT;

   int errs   = 0;
   int checks = 0;

   logic [W-1:0] mult, mcand, q;
   logic [W:0]   acc;
   logic [10:0]  obs;
   logic [10:0]  exp_q[$];

   mult_sequencer #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .Q0(Q0),
      .CLR_A(CLR_A), .LDQ(LDQ), .LDA(LDA), .MULT_EN(MULT_EN), .SR(SR),
      .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   assign obs = {CLR_A, LDQ, LDA, MULT_EN, SR, BUSY, DONE, COUNT};
   assign Q0  = q[0];

   // Datapath the sequencer drives: A (with carry) : Q, multiplicand M.
   always @(posedge CLK) begin
      if (LDQ)   q   <= mult;
      if (CLR_A) acc <= '0;
      if (LDA)   acc <= {1'b0, acc[W-1:0]} + {1'b0, mcand};
      if (SR)    {acc, q} <= {acc, q} >> 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {CLR_A,LDQ,LDA,MULT_EN,SR,BUSY,DONE,COUNT} per cycle from LOAD to DONE.
   function automatic void build(input logic [W-1:0] m);
      exp_q.delete();
      exp_q.push_back({7'b1100010, 4'd0});
      for (int i = 0; i < W; i++) begin
         logic [3:0] c;
         c = 4'(W - 1 - i);
         if (m[i]) begin
            exp_q.push_back({7'b0011010, c});
            exp_q.push_back({7'b0000110, c});
         end else begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
            exp_q.push_back({7'b0000110, c});
`else
            exp_q.push_back({7'b0000010, c});
            exp_q.push_back({7'b0000110, c});
`endif
         end
      end
      exp_q.push_back({7'b0000001, 4'd0});
   endfunction

   function automatic int expected_len(input logic [W-1:0] m);
`ifdef MULT_SEQ_SKIP_ZERO_EN
      return 2 + W + $countones(m);
`else
      return 2 + 2 * W;
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] mc,
                         input int abort_at, input int rst_at);
      int n_sr, n_lda;
      mult = m; mcand = mc; build(m);
      n_sr = 0; n_lda = 0;
      chk("trace_len", exp_q.size(), expected_len(m));
      START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge CLK);
         chk("cycle", 32'(obs), 32'(exp_q[i]));
         n_sr  += int'(SR);
         n_lda += int'(LDA);
         if (i == exp_q.size() - 1) begin
            chk("product", 32'({acc[W-1:0], q}), 32'(m) * 32'(mc));
            chk("sr_pulses", n_sr, W);
            chk("lda_pulses", n_lda, $countones(m));
         end
         if (i == abort_at) begin
            ABORT = 1'b1;
            @(posedge CLK); #1 ABORT = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge CLK);
               chk("abort_idle", 32'(obs), 0);
            end
            return;
         end
         if (i == rst_at) begin
            #2 RST_N = 1'b0;
            #1 chk("rst_async", 32'(obs), 0);
            @(posedge CLK); #1 chk("rst_hold", 32'(obs), 0);
            RST_N = 1'b1;
            return;
         end
      end
      @(negedge CLK);
      chk("idle_after", 32'(obs), 0);
   endtask

   task automatic run_hold(input logic [W-1:0] m, input logic [W-1:0] mc, input int nops);
      mult = m; mcand = mc; build(m);
      START = 1'b1;
      @(posedge CLK); #1;
      for (int op = 0; op < nops; op++) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            chk("hold_cycle", 32'(obs), 32'(exp_q[i]));
         end
         chk("hold_product", 32'({acc[W-1:0], q}), 32'(m) * 32'(mc));
         if (op == nops - 1) START = 1'b0;
         @(negedge CLK);
         chk("hold_idle", 32'(obs), 0);
      end
      @(negedge CLK);
      chk("hold_stop", 32'(obs), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; mult = '0; mcand = '0;
      #12 chk("reset_outs", 32'(obs), 0);
      START = 1'b1;
      @(posedge CLK); #1 chk("reset_ignores_start", 32'(obs), 0);
      START = 1'b0;
      RST_N = 1'b1;
      @(negedge CLK);
      chk("idle", 32'(obs), 0);

      run_op(8'hA5, 8'h3C, -1, -1);
      run_op(8'h00, 8'hFF, -1, -1);
      run_op(8'hFF, 8'hFF, -1, -1);
      run_op(8'h01, 8'h80, -1, -1);
      run_op(8'h80, 8'h01, -1, -1);

      run_op(8'hA5, 8'h11, 4, -1);
      run_op(8'h5A, 8'h23, -1, -1);

      run_op(8'hA5, 8'h07, -1, 2);
      @(negedge CLK);
      run_op(8'hA5, 8'h07, -1, -1);

      START = 1'b1; ABORT = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("start_abort", 32'(obs), 0);
      end
      START = 1'b0; ABORT = 1'b0;

      run_hold(8'hA5, 8'h5B, 2);

      for (int r = 0; r < 8; r++) begin
         logic [W-1:0] rm, rc;
         rm = W'($urandom);
         rc = W'($urandom);
         if (r % 3 == 2)
            run_op(rm, rc, int'($urandom_range(0, 10)), -1);
         else
            run_op(rm, rc, -1, -1);
      end
      run_op(W'($urandom), W'($urandom), -1, -1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
